// File: rtl/cache_pkg.sv
// Shared types and geometry for the cache miss controller: state encoding,
// array dimensions and request-address field positions.
package cache_pkg;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;

   // Request word address = {tag, index, offset}
   localparam int unsigned OFFSET_LSB = 0;
   localparam int unsigned OFFSET_W   = 2;
   localparam int unsigned INDEX_LSB  = 2;
   localparam int unsigned INDEX_W    = 10;
   localparam int unsigned TAG_LSB    = 12;
   localparam int unsigned TAG_W      = 3;

   localparam int unsigned COUNT_W    = 16;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOOKUP  = 3'd1,
      S_FILL    = 3'd2,
      S_WRITE   = 3'd3,
      S_RESPOND = 3'd4
   } state_t;

endpackage

// File: rtl/line_assembler.sv
// Fill buffer: collects one cache line word by word and presents it packed,
// word 0 in the most significant position.
module line_assembler #(
   parameter int unsigned WORD_W     = cache_pkg::WORD_W,
   parameter int unsigned LINE_WORDS = cache_pkg::LINE_WORDS,
   parameter int unsigned SLOT_W     = $clog2(LINE_WORDS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [SLOT_W-1:0]            slot,
   input  logic [WORD_W-1:0]            data,
   output logic [LINE_WORDS*WORD_W-1:0] packed_line
);

   logic [WORD_W-1:0] slots [LINE_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(LINE_WORDS); i++) slots[i] <= '0;
      end else if (wr_en) begin
         slots[slot] <= data;
      end
   end

   always_comb begin
      packed_line = '0;
      for (int i = 0; i < int'(LINE_WORDS); i++)
         packed_line[(int'(LINE_WORDS) - 1 - i) * int'(WORD_W) +: WORD_W] = slots[i];
   end

endmodule

// File: rtl/cache_miss_controller.sv
// CPU-side controller for a direct-mapped cache: probe, fill from memory on miss,
// write the line back and return the requested word. Optional HIT_MISS_COUNT_EN.
module cache_miss_controller
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W     = cache_pkg::ADDR_W,
   parameter int unsigned WORD_W     = cache_pkg::WORD_W,
   parameter int unsigned LINE_WORDS = cache_pkg::LINE_WORDS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cpuRd,
   input  logic [ADDR_W-1:0]            cpuAddr,
   output logic [WORD_W-1:0]            cpuData,
   output logic                         cpuReady,
   output logic [ADDR_W-1:0]            cacheAddr,
   output logic                         cacheWrEn,
   output logic [LINE_WORDS*WORD_W-1:0] cacheLine,
   input  logic                         cacheHit,
   input  logic [WORD_W-1:0]            cacheWord,
   output logic [ADDR_W-1:0]            memAddr,
   output logic                         memRd,
   input  logic [WORD_W-1:0]            memData,
   input  logic                         memReady
`ifdef HIT_MISS_COUNT_EN
   ,
   output logic [COUNT_W-1:0]           hitCount,
   output logic [COUNT_W-1:0]           missCount
`endif
);

   localparam int unsigned OFS_W = $clog2(LINE_WORDS);
   localparam logic [OFS_W-1:0] LAST_SLOT = OFS_W'(LINE_WORDS - 1);

   state_t              state, state_d;
   logic [ADDR_W-1:0]   req_addr, req_addr_d;
   logic [OFS_W-1:0]    cnt, cnt_d;
   logic [WORD_W-1:0]   cpu_data_d;
   logic                cpu_ready_d;
   logic                cache_wr_en_d;
   logic [ADDR_W-1:0]   cache_addr_d;
   logic                mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic                fill_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         req_addr  <= '0;
         cnt       <= '0;
         cpuData   <= '0;
         cpuReady  <= 1'b0;
         cacheWrEn <= 1'b0;
         cacheAddr <= '0;
         memRd     <= 1'b0;
         memAddr   <= '0;
      end else begin
         state     <= state_d;
         req_addr  <= req_addr_d;
         cnt       <= cnt_d;
         cpuData   <= cpu_data_d;
         cpuReady  <= cpu_ready_d;
         cacheWrEn <= cache_wr_en_d;
         cacheAddr <= cache_addr_d;
         memRd     <= mem_rd_d;
         memAddr   <= mem_addr_d;
      end
   end

   // Strobes (cpuReady, cacheWrEn) default low; everything else holds.
   always_comb begin
      state_d       = state;
      req_addr_d    = req_addr;
      cnt_d         = cnt;
      cpu_data_d    = cpuData;
      cpu_ready_d   = 1'b0;
      cache_wr_en_d = 1'b0;
      cache_addr_d  = cacheAddr;
      mem_rd_d      = memRd;
      mem_addr_d    = memAddr;
      fill_we       = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (cpuRd) begin
               req_addr_d   = cpuAddr;
               cache_addr_d = cpuAddr;
               state_d      = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (cacheHit) begin
               cpu_data_d = cacheWord;
               state_d    = S_RESPOND;
            end else begin
               cnt_d      = '0;
               mem_rd_d   = 1'b1;
               mem_addr_d = {req_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            if (memRd && memReady) begin
               fill_we = 1'b1;
               cnt_d   = cnt + OFS_W'(1);
               if (cnt == req_addr[OFS_W-1:0]) cpu_data_d = memData;
               // Last word: memAddr is left on it so it stays stable to the end.
               if (cnt == LAST_SLOT) begin
                  mem_rd_d      = 1'b0;
                  cache_wr_en_d = 1'b1;
                  state_d       = S_WRITE;
               end else begin
                  mem_addr_d = {req_addr[ADDR_W-1:OFS_W], cnt + OFS_W'(1)};
               end
            end
         end
         S_WRITE: begin
            state_d = S_RESPOND;
         end
         S_RESPOND: begin
            cpu_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   line_assembler #(
      .WORD_W     (WORD_W),
      .LINE_WORDS (LINE_WORDS),
      .SLOT_W     (OFS_W)
   ) u_line_assembler (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (fill_we),
      .slot        (cnt),
      .data        (memData),
      .packed_line (cacheLine)
   );

`ifdef HIT_MISS_COUNT_EN
   // Saturating lookup tallies, one count per LOOKUP cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hitCount  <= '0;
         missCount <= '0;
      end else if (state == S_LOOKUP) begin
         if (cacheHit) begin
            if (hitCount != '1) hitCount <= hitCount + COUNT_W'(1);
         end else begin
            if (missCount != '1) missCount <= missCount + COUNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller with a behavioural cache/memory
// model; also covers the HIT_MISS_COUNT_EN counters when that macro is defined.
module tb_cache_miss_controller;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpuRd;
   logic [14:0]  cpuAddr;
   logic [31:0]  cpuData;
   logic         cpuReady;
   logic [14:0]  cacheAddr;
   logic         cacheWrEn;
   logic [127:0] cacheLine;
   logic         cacheHit;
   logic [31:0]  cacheWord;
   logic [14:0]  memAddr;
   logic         memRd;
   logic [31:0]  memData;
   logic         memReady;
`ifdef HIT_MISS_COUNT_EN
   logic [15:0]  hitCount;
   logic [15:0]  missCount;
`endif

   always #5 clk = ~clk;

   cache_miss_controller dut (
      .clk       (clk),
      .rst       (rst),
      .cpuRd     (cpuRd),
      .cpuAddr   (cpuAddr),
      .cpuData   (cpuData),
      .cpuReady  (cpuReady),
      .cacheAddr (cacheAddr),
      .cacheWrEn (cacheWrEn),
      .cacheLine (cacheLine),
      .cacheHit  (cacheHit),
      .cacheWord (cacheWord),
      .memAddr   (memAddr),
      .memRd     (memRd),
      .memData   (memData),
      .memReady  (memReady)
`ifdef HIT_MISS_COUNT_EN
      ,
      .hitCount  (hitCount),
      .missCount (missCount)
`endif
   );

   // Cache array environment, written only by the DUT's cacheWrEn (plus preload)
   logic        cvalid [1024];
   logic [2:0]  ctag   [1024];
   logic [31:0] cdata  [1024][4];
   // Reference model of what the cache should hold
   logic        rvalid [1024];
   logic [2:0]  rtag   [1024];
   logic [31:0] rdata  [1024][4];
   logic [31:0] mem    [32768];

   assign cacheHit  = cvalid[cacheAddr[11:2]] && (ctag[cacheAddr[11:2]] == cacheAddr[14:12]);
   assign cacheWord = cdata[cacheAddr[11:2]][cacheAddr[1:0]];

   int n_checks  = 0;
   int n_fail    = 0;
   int exp_hits  = 0;
   int exp_miss  = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] maddr(input logic [14:0] base, input int k);
      return base + 15'(k);
   endfunction

   // One CPU read; rst_at >= 0 pulses reset once that many words have been filled.
   task automatic do_read(input logic [14:0] addr, input int wait_n, input int rst_at);
      logic [9:0]   idx;
      logic [2:0]   tag;
      logic [1:0]   off;
      logic [14:0]  base;
      logic         exp_hit;
      logic [31:0]  exp_data;
      logic [127:0] exp_line;
      int           exp_lat, n, word_i, waits, mem_cycles, wr_cnt;
      bit           done;
      idx      = addr[11:2];
      tag      = addr[14:12];
      off      = addr[1:0];
      base     = {addr[14:2], 2'b00};
      exp_hit  = rvalid[idx] && (rtag[idx] == tag);
      exp_data = exp_hit ? rdata[idx][off] : mem[addr];
      exp_lat  = exp_hit ? 2 : 3 + 4 * (wait_n + 1);
      exp_line = {mem[maddr(base, 0)], mem[maddr(base, 1)], mem[maddr(base, 2)], mem[maddr(base, 3)]};

      cpuRd   = 1'b1;
      cpuAddr = addr;
      @(posedge clk);
      n = 0; word_i = 0; waits = 0; mem_cycles = 0; wr_cnt = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         cpuRd   = 1'($urandom);
         cpuAddr = 15'($urandom);
         chk("cache_addr", cacheAddr, addr);
         if (rst_at >= 0 && word_i == rst_at) begin
            rst = 1'b1; memReady = 1'b0; cpuRd = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk("rst_cpu_ready", cpuReady, 0);
            chk("rst_wr_en", cacheWrEn, 0);
            chk("rst_mem_rd", memRd, 0);
            chk("rst_mem_addr", memAddr, 0);
            chk("rst_cache_addr", cacheAddr, 0);
            chk("rst_cpu_data", cpuData, 0);
            chk("rst_cache_line", cacheLine, 0);
            chk("rst_no_write", wr_cnt, 0);
            return;
         end
         if (memRd) begin
            mem_cycles++;
            chk("mem_addr", memAddr, maddr(base, word_i));
            if (waits < wait_n) begin
               memReady = 1'b0;
               memData  = 32'($urandom);
               waits++;
            end else begin
               memReady = 1'b1;
               memData  = mem[maddr(base, word_i)];
               word_i++;
               waits = 0;
            end
         end else begin
            memReady = 1'($urandom);
            memData  = 32'($urandom);
         end
         if (cacheWrEn) begin
            wr_cnt++;
            chk("cache_line", cacheLine, exp_line);
            cvalid[cacheAddr[11:2]] = 1'b1;
            ctag[cacheAddr[11:2]]   = cacheAddr[14:12];
            for (int k = 0; k < 4; k++) cdata[cacheAddr[11:2]][k] = cacheLine[(3 - k) * 32 +: 32];
         end
         if (cpuReady) begin
            chk("cpu_data", cpuData, exp_data);
            chk("latency", n, exp_lat);
            chk("mem_rd_cycles", mem_cycles, exp_hit ? 0 : 4 * (wait_n + 1));
            chk("wr_count", wr_cnt, exp_hit ? 0 : 1);
            done = 1;
         end else if (n > 200) begin
            chk("ready_timeout", cpuReady, 1);
            done = 1;
         end else begin
            @(posedge clk);
            n++;
         end
      end
      cpuRd    = 1'b0;
      memReady = 1'b0;
      if (exp_hit) begin
         exp_hits++;
      end else begin
         exp_miss++;
         rvalid[idx] = 1'b1;
         rtag[idx]   = tag;
         for (int k = 0; k < 4; k++) rdata[idx][k] = mem[maddr(base, k)];
      end
   endtask

   task automatic chk_counts();
`ifdef HIT_MISS_COUNT_EN
      chk("hit_count", hitCount, exp_hits);
      chk("miss_count", missCount, exp_miss);
`endif
   endtask

   initial begin
      int idx_set [5];
      logic [31:0] w;
      idx_set = '{5, 8, 9, 3, 1};
      rst = 1'b1; cpuRd = 1'b0; cpuAddr = '0; memData = '0; memReady = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         cvalid[i] = 1'b0; rvalid[i] = 1'b0; ctag[i] = '0; rtag[i] = '0;
         for (int k = 0; k < 4; k++) begin cdata[i][k] = '0; rdata[i][k] = '0; end
      end
      for (int i = 0; i < 32768; i++) mem[i] = $urandom;
      for (int k = 0; k < 4; k++) mem[4 + k] = 32'hA0 + 32'(k);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cpu_ready", cpuReady, 0);
      chk("reset_cpu_data", cpuData, 0);
      chk("reset_wr_en", cacheWrEn, 0);
      chk("reset_cache_line", cacheLine, 0);
      chk("reset_mem_rd", memRd, 0);
      chk("reset_mem_addr", memAddr, 0);
      chk("reset_cache_addr", cacheAddr, 0);
      chk_counts();
      rst = 1'b0;

      // Preload index 5, tag 3
      for (int k = 0; k < 4; k++) begin
         w = $urandom;
         cdata[5][k] = w; rdata[5][k] = w;
      end
      cvalid[5] = 1'b1; ctag[5] = 3'd3; rvalid[5] = 1'b1; rtag[5] = 3'd3;
      @(negedge clk);

      do_read(15'h3016, 0, -1);
      do_read(15'h0007, 0, -1);
      chk("cold_miss_data", cpuData, 32'hA3);
      do_read(15'h0007, 0, -1);
      do_read(15'h0123, 3, -1);
      do_read(15'h1008, 0, -1);
      do_read(15'h2008, 1, -1);
      do_read(15'h1008, 0, -1);
      chk_counts();

      for (int i = 0; i < 25; i++)
         do_read({3'($urandom_range(0, 3)), 10'(idx_set[$urandom_range(0, 4)]), 2'($urandom)},
                 $urandom_range(0, 2), -1);
      chk_counts();

      do_read(15'h7FF1, 0, 2);
      exp_hits = 0;
      exp_miss = 0;
      chk_counts();
      @(negedge clk);
      do_read(15'h7FF1, 0, -1);
      chk_counts();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
